// File: rtl/fir_stream_core.sv
// fir_stream_core: single-MAC, TAPS-tap FIR engine with AXI-Stream input and output.
// Ports:
//   axis_clk, axis_rst_n              clock, synchronous active-low reset
//   ap_start, data_length             run start pulse and sample count (honoured in idle)
//   ap_idle, ap_done                  idle level and one-cycle end-of-run pulse
//   tap_we, tap_addr, tap_wdata       coefficient write port (idle only)
//   ss_tvalid/ss_tready/ss_tdata/ss_tlast   input sample stream
//   sm_tvalid/sm_tready/sm_tdata/sm_tlast   output result stream
//   err_tlast                         sticky: ss_tlast disagreed with data_length
module fir_stream_core #(
  parameter int unsigned TAPS = 11,
  parameter int unsigned DW   = 32
) (
  input  logic          axis_clk,
  input  logic          axis_rst_n,
  input  logic          ap_start,
  input  logic [31:0]   data_length,
  output logic          ap_idle,
  output logic          ap_done,
  input  logic          tap_we,
  input  logic [3:0]    tap_addr,
  input  logic [DW-1:0] tap_wdata,
  input  logic          ss_tvalid,
  output logic          ss_tready,
  input  logic [DW-1:0] ss_tdata,
  input  logic          ss_tlast,
  output logic          sm_tvalid,
  input  logic          sm_tready,
  output logic [DW-1:0] sm_tdata,
  output logic          sm_tlast,
  output logic          err_tlast
);

  localparam int unsigned KW = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT_IN = 3'd1,
    S_MAC     = 3'd2,
    S_OUT     = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DW-1:0] r_h [TAPS];
  logic [DW-1:0] r_x [TAPS];
  logic [DW-1:0] r_acc;
  logic [31:0]   r_len;
  logic [31:0]   r_count;
  logic [KW-1:0] r_k;

  logic          r_ap_idle;
  logic          r_ap_done;
  logic          r_ss_tready;
  logic          r_sm_tvalid;
  logic [DW-1:0] r_sm_tdata;
  logic          r_sm_tlast;
  logic          r_err_tlast;

  logic          w_last_cnt;
  logic          w_mac_last;
  logic [DW-1:0] w_prod_lo;

  assign w_last_cnt = (r_count == r_len - 32'd1);
  assign w_mac_last = (r_k == KW'(TAPS - 1));
  // Low DW bits of the full 2*DW signed product
  assign w_prod_lo  = DW'($signed((2*DW)'($signed(r_h[r_k]))) * $signed((2*DW)'($signed(r_x[r_k]))));

  // State register
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (ap_start) w_state_nxt = (data_length == 32'd0) ? S_DONE : S_WAIT_IN;
      S_WAIT_IN: if (ss_tvalid) w_state_nxt = S_MAC;
      S_MAC:     if (w_mac_last) w_state_nxt = S_OUT;
      S_OUT:     if (sm_tready) w_state_nxt = (r_count + 32'd1 == r_len) ? S_DONE : S_WAIT_IN;
      S_DONE:    w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: coefficients, history, accumulator, counters, registered outputs
  always_ff @(posedge axis_clk) begin
    if (!axis_rst_n) begin
      for (int i = 0; i < int'(TAPS); i++) begin
        r_h[i] <= '0;
        r_x[i] <= '0;
      end
      r_acc       <= '0;
      r_len       <= '0;
      r_count     <= '0;
      r_k         <= '0;
      r_ap_idle   <= 1'b1;
      r_ap_done   <= 1'b0;
      r_ss_tready <= 1'b0;
      r_sm_tvalid <= 1'b0;
      r_sm_tdata  <= '0;
      r_sm_tlast  <= 1'b0;
      r_err_tlast <= 1'b0;
    end else begin
      if (r_state == S_IDLE && tap_we && 32'(tap_addr) < TAPS) r_h[tap_addr] <= tap_wdata;

      case (r_state)
        S_IDLE: begin
          if (ap_start && data_length != 32'd0) begin
            r_len       <= data_length;
            r_count     <= '0;
            r_err_tlast <= 1'b0;
            for (int i = 0; i < int'(TAPS); i++) r_x[i] <= '0;
          end
        end
        S_WAIT_IN: begin
          if (ss_tvalid) begin
            for (int i = int'(TAPS) - 1; i > 0; i--) r_x[i] <= r_x[i-1];
            r_x[0] <= ss_tdata;
            r_acc  <= '0;
            r_k    <= '0;
            if (ss_tlast != w_last_cnt) r_err_tlast <= 1'b1;
          end
        end
        S_MAC: begin
          r_acc <= r_acc + w_prod_lo;
          r_k   <= r_k + KW'(1);
          // Final sum captured for the output stage
          if (w_mac_last) r_sm_tdata <= r_acc + w_prod_lo;
        end
        S_OUT: begin
          if (sm_tready) r_count <= r_count + 32'd1;
        end
        default: ;
      endcase

      r_ap_idle   <= (w_state_nxt == S_IDLE);
      r_ap_done   <= (w_state_nxt == S_DONE);
      r_ss_tready <= (w_state_nxt == S_WAIT_IN);
      r_sm_tvalid <= (w_state_nxt == S_OUT);
      r_sm_tlast  <= (w_state_nxt == S_OUT) && w_last_cnt;
    end
  end

  assign ap_idle   = r_ap_idle;
  assign ap_done   = r_ap_done;
  assign ss_tready = r_ss_tready;
  assign sm_tvalid = r_sm_tvalid;
  assign sm_tdata  = r_sm_tdata;
  assign sm_tlast  = r_sm_tlast;
  assign err_tlast = r_err_tlast;

endmodule

// File: tb/tb_fir_stream_core.sv
// Testbench for fir_stream_core: randomized streams checked by a scoreboard fed from
// a direct convolution model, plus the fixed step/impulse/wrap/tlast/reset scenarios.
module tb_fir_stream_core;

  localparam int TAPS = 11;
  localparam int DW   = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ap_start;
  logic [31:0]   data_length;
  logic          ap_idle;
  logic          ap_done;
  logic          tap_we;
  logic [3:0]    tap_addr;
  logic [DW-1:0] tap_wdata;
  logic          ss_tvalid;
  logic          ss_tready;
  logic [DW-1:0] ss_tdata;
  logic          ss_tlast;
  logic          sm_tvalid;
  logic          sm_tready;
  logic [DW-1:0] sm_tdata;
  logic          sm_tlast;
  logic          err_tlast;

  always #5 clk = ~clk;

  fir_stream_core #(.TAPS(TAPS), .DW(DW)) dut (
    .axis_clk    (clk),
    .axis_rst_n  (rst_n),
    .ap_start    (ap_start),
    .data_length (data_length),
    .ap_idle     (ap_idle),
    .ap_done     (ap_done),
    .tap_we      (tap_we),
    .tap_addr    (tap_addr),
    .tap_wdata   (tap_wdata),
    .ss_tvalid   (ss_tvalid),
    .ss_tready   (ss_tready),
    .ss_tdata    (ss_tdata),
    .ss_tlast    (ss_tlast),
    .sm_tvalid   (sm_tvalid),
    .sm_tready   (sm_tready),
    .sm_tdata    (sm_tdata),
    .sm_tlast    (sm_tlast),
    .err_tlast   (err_tlast)
  );

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_out    = 0;
  bit          bp_en    = 1'b0;
  exp_t        exp_q[$];
  logic [31:0] tb_h [TAPS];

  int step_h [TAPS] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};
  int step_y [TAPS] = '{0, -10, -19, 4, 60, 123, 179, 202, 193, 183, 183};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Output monitor: pops the scoreboard on each output handshake, checks hold while stalled
  initial begin
    bit          stalled;
    logic [31:0] hd;
    logic        hl;
    exp_t        e;
    stalled = 1'b0;
    hd = '0;
    hl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || !sm_tvalid) begin
        stalled = 1'b0;
      end else begin
        if (stalled) begin
          check("stall_hold_data", sm_tdata, hd);
          check("stall_hold_last", 32'(sm_tlast), 32'(hl));
        end
        if (sm_tready) begin
          stalled = 1'b0;
          n_out++;
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_output: got 0x%08h, expected no output", sm_tdata);
          end else begin
            e = exp_q.pop_front();
            check("result_data", sm_tdata, e.data);
            check("result_last", 32'(sm_tlast), 32'(e.last));
          end
        end else begin
          stalled = 1'b1;
          hd = sm_tdata;
          hl = sm_tlast;
        end
      end
    end
  end

  // Output backpressure source
  initial begin
    sm_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      sm_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic write_tap(input int addr, input logic [31:0] val);
    tap_addr  = 4'(addr);
    tap_wdata = val;
    tap_we    = 1'b1;
    tick();
    tap_we    = 1'b0;
    if (addr < TAPS) tb_h[addr] = val;
  endtask

  task automatic load_step_h();
    for (int i = 0; i < TAPS; i++) write_tap(i, 32'(step_h[i]));
  endtask

  // Direct convolution with x[n<0]=0, wrapping to 32 bits
  task automatic push_model(input logic [31:0] xs[$]);
    logic [31:0] acc;
    exp_t        e;
    for (int n = 0; n < xs.size(); n++) begin
      acc = '0;
      for (int k = 0; k < TAPS; k++)
        if (n >= k) acc = acc + 32'(longint'($signed(tb_h[k])) * longint'($signed(xs[n-k])));
      e.data = acc;
      e.last = (n == xs.size() - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_step();
    exp_t e;
    for (int n = 0; n < TAPS; n++) begin
      e.data = 32'(step_y[n]);
      e.last = (n == TAPS - 1);
      exp_q.push_back(e);
    end
  endtask

  // One run: start, stream xs in, wait for ap_done, verify pulse and output count
  task automatic run(input logic [31:0] xs[$], input int tlast_at, input bit poke);
    int len;
    int out0;
    int to;
    len  = xs.size();
    out0 = n_out;
    data_length = 32'(len);
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    fork
      begin
        for (int i = 0; i < len; i++) begin
          ss_tdata  = xs[i];
          ss_tlast  = (tlast_at < 0) ? (i == len - 1) : (i == tlast_at);
          ss_tvalid = 1'b1;
          to = 0;
          do begin
            @(negedge clk);
            to++;
          end while (!ss_tready && to < 3000);
          if (!ss_tready) begin
            n_checks++;
            $display("FAIL input_timeout: sample %0d not accepted, expected ss_tready", i);
            break;
          end
          @(posedge clk);
          #1;
          ss_tvalid = 1'b0;
          ss_tlast  = 1'b0;
          if (bp_en) repeat ($urandom_range(0, 2)) tick();
        end
      end
      begin
        if (poke) begin
          repeat (30) tick();
          ap_start    = 1'b1;
          data_length = 32'd3;
          tap_we      = 1'b1;
          tap_addr    = 4'd3;
          tap_wdata   = 32'h1234_5678;
          tick();
          ap_start = 1'b0;
          tap_we   = 1'b0;
        end
      end
    join
    to = 0;
    @(negedge clk);
    while (!ap_done && to < 3000) begin
      @(negedge clk);
      to++;
    end
    check("ap_done_seen", 32'(ap_done), 32'd1);
    if (len == 0) begin
      check("done_latency_len0", 32'(to), 32'd0);
      check("no_tready_len0", 32'(ss_tready), 32'd0);
    end
    @(negedge clk);
    check("ap_done_one_cycle", 32'(ap_done), 32'd0);
    check("ap_idle_after_done", 32'(ap_idle), 32'd1);
    check("output_count", 32'(n_out - out0), 32'(len));
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    tick();
  endtask

  initial begin
    logic [31:0] xs[$];
    int          to;

    rst_n = 1'b0;
    ap_start = 1'b0;
    data_length = '0;
    tap_we = 1'b0;
    tap_addr = '0;
    tap_wdata = '0;
    ss_tvalid = 1'b0;
    ss_tdata = '0;
    ss_tlast = 1'b0;
    for (int i = 0; i < TAPS; i++) tb_h[i] = '0;
    repeat (3) tick();
    check("rst_ap_idle", 32'(ap_idle), 32'd1);
    check("rst_ap_done", 32'(ap_done), 32'd0);
    check("rst_ss_tready", 32'(ss_tready), 32'd0);
    check("rst_sm_tvalid", 32'(sm_tvalid), 32'd0);
    check("rst_sm_tlast", 32'(sm_tlast), 32'd0);
    check("rst_err_tlast", 32'(err_tlast), 32'd0);
    check("rst_sm_tdata", sm_tdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // Step response, including an out-of-range coefficient write that must be ignored
    load_step_h();
    write_tap(13, 32'hDEAD_BEEF);
    xs.delete();
    for (int i = 0; i < TAPS; i++) xs.push_back(32'd1);
    push_step();
    run(xs, -1, 1'b0);
    check("step_err_tlast", 32'(err_tlast), 32'd0);

    // Back-to-back step run with ap_start and tap_we poked mid-run
    push_step();
    run(xs, -1, 1'b1);
    check("b2b_err_tlast", 32'(err_tlast), 32'd0);
    push_step();
    run(xs, -1, 1'b0);

    // Impulse with random output backpressure
    bp_en = 1'b1;
    xs.delete();
    xs.push_back(32'd1);
    for (int i = 1; i < TAPS; i++) xs.push_back(32'd0);
    push_model(xs);
    run(xs, -1, 1'b0);
    bp_en = 1'b0;

    // Wraparound: 2 * 0x7FFFFFFF
    write_tap(0, 32'd2);
    for (int i = 1; i < TAPS; i++) write_tap(i, 32'd0);
    xs.delete();
    xs.push_back(32'h7FFF_FFFF);
    begin
      exp_t e;
      e.data = 32'hFFFF_FFFE;
      e.last = 1'b1;
      exp_q.push_back(e);
    end
    run(xs, -1, 1'b0);

    // Zero-length run
    xs.delete();
    run(xs, -1, 1'b0);

    // tlast on sample 2 of 4
    for (int i = 0; i < TAPS; i++) write_tap(i, $urandom());
    xs.delete();
    for (int i = 0; i < 4; i++) xs.push_back($urandom());
    push_model(xs);
    run(xs, 1, 1'b0);
    check("tlast_err_set", 32'(err_tlast), 32'd1);
    repeat (3) tick();
    check("tlast_err_sticky", 32'(err_tlast), 32'd1);

    // Random coefficients and samples with backpressure
    bp_en = 1'b1;
    for (int i = 0; i < TAPS; i++) write_tap(i, 32'($signed(16'($urandom()))));
    xs.delete();
    for (int i = 0; i < 20; i++) xs.push_back($urandom());
    push_model(xs);
    run(xs, -1, 1'b0);
    bp_en = 1'b0;

    // Reset during MAC, then step run from cleared state
    load_step_h();
    data_length = 32'd11;
    ap_start = 1'b1;
    tick();
    ap_start  = 1'b0;
    ss_tdata  = 32'd7;
    ss_tvalid = 1'b1;
    to = 0;
    do begin
      @(negedge clk);
      to++;
    end while (!ss_tready && to < 100);
    check("midrst_tready", 32'(ss_tready), 32'd1);
    @(posedge clk);
    #1;
    ss_tvalid = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("midrst_ap_idle", 32'(ap_idle), 32'd1);
    check("midrst_sm_tvalid", 32'(sm_tvalid), 32'd0);
    check("midrst_sm_tdata", sm_tdata, 32'd0);
    check("midrst_err_tlast", 32'(err_tlast), 32'd0);
    rst_n = 1'b1;
    exp_q.delete();
    for (int i = 0; i < TAPS; i++) tb_h[i] = '0;
    tick();
    load_step_h();
    xs.delete();
    for (int i = 0; i < TAPS; i++) xs.push_back(32'd1);
    push_step();
    run(xs, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
